data_bus_if: RTL and testbench



---
 rtl/data_bus_if_pkg.sv | 17 +
 rtl/data_bus_if.sv | 110 +++++++++++
 tb/tb_data_bus_if.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_if_pkg.sv
// Shared constants and FSM encoding for the data-side Wishbone bridge.
package data_bus_if_pkg;

  localparam int          RegBus    = 32;
  localparam int          StallBit  = 4;   // access-stage hold bit in stall_i
  localparam logic        RstEnable = 1'b1;
  localparam logic        Stop      = 1'b1;
  localparam logic        NoStop    = 1'b0;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    BUSY       = 2'b01,
    WAIT_STALL = 2'b11
  } state_e;

endpackage

// File: rtl/data_bus_if.sv
// Data-side bridge: turns the access stage's one-cycle RAM request into a
// Wishbone B3 classic cycle and stalls the pipeline until the slave acks.
module data_bus_if
  import data_bus_if_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall_i,
  input  logic              flush_i,
  input  logic              cpu_ce_i,
  input  logic [RegBus-1:0] cpu_addr_i,
  input  logic [RegBus-1:0] cpu_data_i,
  input  logic              cpu_we_i,
  input  logic [3:0]        cpu_sel_i,
  output logic [RegBus-1:0] cpu_data_o,
  output logic              stallreq,
  input  logic [RegBus-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  output logic [RegBus-1:0] wb_adr_o,
  output logic [RegBus-1:0] wb_dat_o,
  output logic              wb_we_o,
  output logic [3:0]        wb_sel_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o
);

  state_e            state, state_nxt;
  logic [RegBus-1:0] rd_buf;

  always_comb begin
    state_nxt  = state;
    stallreq   = NoStop;
    cpu_data_o = ZeroWord;
    case (state)
      IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          state_nxt = BUSY;
          stallreq  = Stop;
        end
      end
      BUSY: begin
        // ack wins over a same-cycle flush; the pipeline discards the data
        if (wb_ack_i) begin
          state_nxt = stall_i[StallBit] ? WAIT_STALL : IDLE;
          if (!wb_we_o) cpu_data_o = wb_dat_i;
        end else begin
          stallreq = Stop;
          if (flush_i) state_nxt = IDLE;
        end
      end
      WAIT_STALL: begin
        cpu_data_o = rd_buf;
        if (!stall_i[StallBit] || flush_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst == RstEnable) begin
      stallreq   = NoStop;
      cpu_data_o = ZeroWord;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state    <= IDLE;
      wb_adr_o <= ZeroWord;
      wb_dat_o <= ZeroWord;
      wb_we_o  <= 1'b0;
      wb_sel_o <= 4'b0000;
      wb_stb_o <= 1'b0;
      wb_cyc_o <= 1'b0;
      rd_buf   <= ZeroWord;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cpu_ce_i && !flush_i) begin
            wb_adr_o <= cpu_addr_i;
            wb_dat_o <= cpu_data_i;
            wb_we_o  <= cpu_we_i;
            wb_sel_o <= cpu_sel_i;
            wb_stb_o <= 1'b1;
            wb_cyc_o <= 1'b1;
          end
        end
        BUSY: begin
          if (wb_ack_i) begin
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= 4'b0000;
            wb_adr_o <= ZeroWord;
            if (!wb_we_o) rd_buf <= wb_dat_i;
          end else if (flush_i) begin
            // abort: the slave has to cope with cyc dropping mid-cycle
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= 4'b0000;
            wb_adr_o <= ZeroWord;
            wb_dat_o <= ZeroWord;
            rd_buf   <= ZeroWord;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_if.sv
// Randomized bench for data_bus_if: transaction scoreboard plus a
// cycle monitor that derives expected outputs from the bus protocol rules.
module tb_data_bus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i, cpu_data_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_o;
  logic        stallreq;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o, wb_cyc_o;

  data_bus_if dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
    .stallreq(stallreq), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // slave controls
  int          next_waits = 0;
  bit          stray_ack  = 0;
  bit          rand_stray = 0;
  bit          force_en   = 0;
  logic [31:0] force_dat  = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Wishbone slave: counts wait states per cycle, may raise stray acks when idle
  initial begin
    int  waits_left = 0;
    bit  in_txn     = 0;
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(posedge clk); #2;
      if (wb_cyc_o) begin
        if (!in_txn) begin in_txn = 1; waits_left = next_waits; end
        if (waits_left == 0) begin
          wb_ack_i = 1'b1;
          wb_dat_i = force_en ? force_dat : $urandom;
          in_txn   = 0;
        end else begin
          wb_ack_i = 1'b0;
          wb_dat_i = $urandom;
          waits_left--;
        end
      end else begin
        in_txn   = 0;
        wb_ack_i = stray_ack || (rand_stray && $urandom_range(0, 3) == 0);
        wb_dat_i = $urandom;
      end
    end
  end

  // Monitor: reference model of the bridge at transaction level
  initial begin
    bit          prev_rst  = 0;
    bit          held      = 0;
    logic [31:0] held_data = '0;
    txn_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_stallreq", {31'b0, stallreq}, 32'd0);
        chk("rst_cpu_data", cpu_data_o, 32'd0);
        exp_q.delete();
        held = 0; held_data = '0; prev_rst = 1;
      end else begin
        if (prev_rst) begin
          chk("post_rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 32'd0);
          chk("post_rst_adr", wb_adr_o, 32'd0);
          chk("post_rst_dat", wb_dat_o, 32'd0);
        end
        prev_rst = 0;
        if (held) begin
          chk("hold_stallreq", {31'b0, stallreq}, 32'd0);
          chk("hold_cpu_data", cpu_data_o, held_data);
          chk("hold_cyc", {31'b0, wb_cyc_o}, 32'd0);
          held = stall_i[4] && !flush_i;
        end else if (wb_cyc_o) begin
          if (exp_q.size() == 0) begin
            chk("cyc_without_request", {31'b0, wb_cyc_o}, 32'd0);
          end else begin
            e = exp_q[0];
            chk("bus_adr", wb_adr_o, e.adr);
            chk("bus_dat", wb_dat_o, e.dat);
            chk("bus_ctl", {wb_stb_o, wb_we_o, wb_sel_o}, {26'b0, 1'b1, e.we, e.sel});
            if (wb_ack_i) begin
              chk("ack_stallreq", {31'b0, stallreq}, 32'd0);
              chk("ack_cpu_data", cpu_data_o, e.we ? 32'd0 : wb_dat_i);
              if (!e.we) held_data = wb_dat_i;
              held = stall_i[4];
              void'(exp_q.pop_front());
            end else begin
              chk("wait_stallreq", {31'b0, stallreq}, 32'd1);
              chk("wait_cpu_data", cpu_data_o, 32'd0);
              if (flush_i) begin
                held_data = '0;
                void'(exp_q.pop_front());
              end
            end
          end
        end else begin
          chk("idle_stallreq", {31'b0, stallreq}, {31'b0, cpu_ce_i && !flush_i});
          chk("idle_cpu_data", cpu_data_o, 32'd0);
        end
      end
    end
  end

  // Access-stage side: entered and left at posedge+1.
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int waits, input int hold, input bit fa);
    int k = 0;
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_data_i = d; cpu_sel_i = s;
    flush_i = 1'b0;
    stall_i = 6'($urandom);
    stall_i[4] = (hold > 0);
    next_waits = waits;
    exp_q.push_back('{adr: a, dat: d, we: we, sel: s});
    forever begin
      @(negedge clk);
      if (!stallreq) break;
      if (k > 20) begin
        checks++; errors++;
        $display("FAIL ack_timeout: stallreq still 1 after %0d cycles", k);
        break;
      end
      @(posedge clk); #1;
      if (k == waits) flush_i = fa;
      k++;
    end
    @(posedge clk); #1;
    flush_i = 1'b0;
    if (hold > 0) begin
      repeat (hold - 1) begin @(posedge clk); #1; end
      stall_i[4] = 1'b0;
      @(posedge clk); #1;
    end
    cpu_ce_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1; stall_i = '0; flush_i = 1'b0; cpu_ce_i = 1'b0;
    cpu_addr_i = '0; cpu_data_i = '0; cpu_we_i = 1'b0; cpu_sel_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // zero-wait read, then waited write
    force_en = 1; force_dat = 32'hDEAD_BEEF;
    issue(1'b0, 32'h0000_0104, 32'h0, 4'b1111, 0, 0, 0);
    idle(1);
    issue(1'b1, 32'h0000_0200, 32'h1234_5678, 4'b0011, 3, 0, 0);
    idle(1);
    // read completed while the access stage is held for two more cycles
    force_dat = 32'hCAFE_0001;
    issue(1'b0, 32'h0000_0300, 32'h0, 4'b1100, 1, 2, 0);
    force_en = 0;
    idle(1);

    // flush mid-BUSY, followed by an ack that must be ignored
    cpu_ce_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h0000_0400; cpu_sel_i = 4'b1111;
    next_waits = 8; stall_i = '0;
    exp_q.push_back('{adr: 32'h0000_0400, dat: cpu_data_i, we: 1'b0, sel: 4'b1111});
    idle(1);
    idle(1); flush_i = 1; cpu_ce_i = 0;
    idle(1); flush_i = 0; stray_ack = 1;
    idle(1); stray_ack = 0;
    idle(1);

    // flush while idle with a request present: nothing is started
    cpu_ce_i = 1; flush_i = 1;
    idle(1); cpu_ce_i = 0; flush_i = 0;
    idle(2);

    // reset in the middle of a waited write
    cpu_ce_i = 1; cpu_we_i = 1; cpu_addr_i = 32'h0000_0500; cpu_data_i = 32'hA5A5_5A5A;
    cpu_sel_i = 4'b1000; next_waits = 8;
    exp_q.push_back('{adr: 32'h0000_0500, dat: 32'hA5A5_5A5A, we: 1'b1, sel: 4'b1000});
    idle(1); cpu_ce_i = 0;
    idle(1); rst = 1;
    idle(1); rst = 0;
    idle(2);

    // back-to-back store then load, ack coinciding with flush, flush during hold
    issue(1'b1, 32'h0000_0600, 32'h0BAD_F00D, 4'b1111, 0, 0, 0);
    issue(1'b0, 32'h0000_0604, 32'h0, 4'b1111, 0, 0, 0);
    issue(1'b0, 32'h0000_0608, 32'h0, 4'b0110, 2, 0, 1);
    issue(1'b0, 32'h0000_060C, 32'h0, 4'b1111, 0, 1, 1);
    idle(1);
    issue(1'b0, 32'h0000_0610, 32'h0, 4'b1111, 1, 3, 0);
    idle(1);

    // randomized traffic with stray acks while idle
    rand_stray = 1;
    for (int t = 0; t < 80; t++) begin
      int hold;
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      issue(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
            int'($urandom_range(0, 3)), hold, $urandom_range(0, 7) == 0);
      idle(int'($urandom_range(0, 2)));
    end
    rand_stray = 0;
    idle(4);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
